// File: rtl/base64_decode_block_pkg.sv
// Shared types, character constants and the ASCII-to-sextet lookup for the
// block Base64 decoder.
package base64_decode_block_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] PAD_CHAR   = 8'h3D;
  localparam logic [7:0] UC_LO      = 8'h41;
  localparam logic [7:0] UC_HI      = 8'h5A;
  localparam logic [7:0] LC_LO      = 8'h61;
  localparam logic [7:0] LC_HI      = 8'h7A;
  localparam logic [7:0] DG_LO      = 8'h30;
  localparam logic [7:0] DG_HI      = 8'h39;
  localparam logic [7:0] PLUS_CHAR  = 8'h2B;
  localparam logic [7:0] SLASH_CHAR = 8'h2F;

  typedef struct packed {
    logic       ok;
    logic       pad;
    logic [5:0] sextet;
  } sext_t;

  // Anything that is neither alphabet nor '=' comes back with ok=0, pad=0
  // and a zero sextet, so illegal characters decode as 0.
  function automatic sext_t char2sextet(input logic [7:0] c);
    sext_t r;
    r = '0;
    if (c >= UC_LO && c <= UC_HI) begin
      r.ok     = 1'b1;
      r.sextet = 6'(c - UC_LO);
    end else if (c >= LC_LO && c <= LC_HI) begin
      r.ok     = 1'b1;
      r.sextet = 6'(c - LC_LO + 8'd26);
    end else if (c >= DG_LO && c <= DG_HI) begin
      r.ok     = 1'b1;
      r.sextet = 6'(c - DG_LO + 8'd52);
    end else if (c == PLUS_CHAR) begin
      r.ok     = 1'b1;
      r.sextet = 6'd62;
    end else if (c == SLASH_CHAR) begin
      r.ok     = 1'b1;
      r.sextet = 6'd63;
    end else if (c == PAD_CHAR) begin
      r.pad    = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/base64_decode_block_if.sv
// Block handshake bundle: producer drives the ASCII block and the result
// acknowledge, decoder returns status and the decoded bytes.
interface base64_decode_block_if #(
  parameter int IN_CHARS = 640
);
  logic                    data_valid;
  logic [8*IN_CHARS-1:0]   data_in;
  logic                    read;
  logic                    busy;
  logic                    finish;
  logic                    error;
  logic [1:0]              pad_cnt;
  logic [6*IN_CHARS-1:0]   data_out;

  modport master (
    output data_valid, data_in, read,
    input  busy, finish, error, pad_cnt, data_out
  );

  modport slave (
    input  data_valid, data_in, read,
    output busy, finish, error, pad_cnt, data_out
  );
endinterface

// File: rtl/base64_decode_block_quantum_dec.sv
// Combinational decode of one 4-character quantum into 3 bytes, with
// padding-form and illegal-character detection.
module base64_quantum_dec
  import base64_decode_block_pkg::*;
(
  input  logic [31:0] q_chars_i,
  input  logic        is_last_i,
  output logic [23:0] bytes_o,
  output logic [1:0]  pad_o,
  output logic        bad_o
);

  sext_t s [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_char
      assign s[gi] = char2sextet(q_chars_i[31-8*gi -: 8]);
    end
  endgenerate

  logic pad1_form;
  logic pad2_form;
  logic any_pad;
  logic any_illegal;

  // Classify the pad pattern, flag errors and blank the padded byte lanes.
  always_comb begin
    pad2_form   = !s[0].pad && !s[1].pad && s[2].pad && s[3].pad;
    pad1_form   = !s[0].pad && !s[1].pad && !s[2].pad && s[3].pad;
    any_pad     = s[0].pad | s[1].pad | s[2].pad | s[3].pad;
    any_illegal = (!s[0].ok && !s[0].pad) || (!s[1].ok && !s[1].pad) ||
                  (!s[2].ok && !s[2].pad) || (!s[3].ok && !s[3].pad);
    bad_o       = any_illegal || (any_pad && !(is_last_i && (pad1_form || pad2_form)));
    pad_o       = 2'd0;
    if (is_last_i && pad2_form) begin
      pad_o = 2'd2;
    end else if (is_last_i && pad1_form) begin
      pad_o = 2'd1;
    end
    bytes_o = {s[0].sextet, s[1].sextet, s[2].sextet, s[3].sextet};
    if (pad_o == 2'd2) begin
      bytes_o[15:0] = 16'h0000;
    end else if (pad_o == 2'd1) begin
      bytes_o[7:0] = 8'h00;
    end
  end

endmodule

// File: rtl/base64_decode_block.sv
// Block Base64 decoder: captures a whole ASCII block, decodes QPC quanta per
// cycle through a one-stage decode pipeline, then holds the result until read.
module base64_decode_block
  import base64_decode_block_pkg::*;
#(
  parameter int IN_CHARS = 640,
  parameter int QPC      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  base64_decode_block_if.slave bus
);

  localparam int NQ    = IN_CHARS / 4;
  localparam int NCYC  = NQ / QPC;
  localparam int OUT_W = 6 * IN_CHARS;
  localparam int CW    = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

  state_e                     state_q, state_d;
  logic [8*IN_CHARS-1:0]      shadow_q;
  logic [CW-1:0]              cnt_q;
  logic                       dec_vld_q;
  logic [CW-1:0]              dec_cnt_q;
  logic [QPC-1:0][23:0]       dec_bytes_q;
  logic                       dec_bad_q;
  logic [1:0]                 dec_pad_q;
  logic [OUT_W-1:0]           data_out_q;
  logic                       error_q;
  logic [1:0]                 pad_q;

  logic [QPC-1:0][23:0]       lane_bytes;
  logic [QPC-1:0][1:0]        lane_pad;
  logic [QPC-1:0]             lane_bad;

  generate
    for (genvar gi = 0; gi < QPC; gi++) begin : g_lane
      logic [31:0] lane_chars;
      logic        lane_last;
      assign lane_chars = shadow_q[32*(int'(cnt_q)*QPC+gi) +: 32];
      assign lane_last  = (int'(cnt_q)*QPC + gi) == (NQ - 1);
      base64_quantum_dec u_dec (
        .q_chars_i (lane_chars),
        .is_last_i (lane_last),
        .bytes_o   (lane_bytes[gi]),
        .pad_o     (lane_pad[gi]),
        .bad_o     (lane_bad[gi])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: WORK ends once the final slice group has left the decode stage.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.data_valid) state_d = WORK;
      WORK:    if (dec_vld_q && dec_cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (bus.read) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the block, step the quantum counter and register the lane results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      dec_vld_q   <= 1'b0;
      dec_cnt_q   <= '0;
      dec_bytes_q <= '0;
      dec_bad_q   <= 1'b0;
      dec_pad_q   <= 2'd0;
    end else begin
      dec_vld_q <= 1'b0;
      if (state_q == IDLE && bus.data_valid) begin
        shadow_q <= bus.data_in;
        cnt_q    <= '0;
      end else if (state_q == WORK) begin
        dec_vld_q   <= 1'b1;
        dec_cnt_q   <= cnt_q;
        dec_bytes_q <= lane_bytes;
        dec_bad_q   <= |lane_bad;
        // Only the lane holding the final quantum can report padding.
        dec_pad_q   <= 2'd0;
        for (int i = 0; i < QPC; i++) begin
          if (lane_pad[i] != 2'd0) dec_pad_q <= lane_pad[i];
        end
        if (cnt_q != LAST_CNT) cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Write decoded slices into the result and accumulate block status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q <= '0;
      error_q    <= 1'b0;
      pad_q      <= 2'd0;
    end else if (state_q == IDLE && bus.data_valid) begin
      error_q <= 1'b0;
      pad_q   <= 2'd0;
    end else if (state_q == WORK && dec_vld_q) begin
      for (int i = 0; i < QPC; i++) begin
        data_out_q[24*(int'(dec_cnt_q)*QPC+i) +: 24] <= dec_bytes_q[i];
      end
      if (dec_bad_q) error_q <= 1'b1;
      if (dec_cnt_q == LAST_CNT) pad_q <= dec_pad_q;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.finish   = (state_q == DONE);
  assign bus.error    = error_q;
  assign bus.pad_cnt  = pad_q;
  assign bus.data_out = data_out_q;

endmodule
